// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter.
// One shared single-port instruction memory is driven by three requesters:
// the fetch stage (IF), the program loader (LD, writes) and the debug port
// (DBG, reads). The grant is combinational from the current requests and a
// small amount of registered state (burst counter, round-robin pointer,
// owner of the read in flight). Read data is never registered here; consumers
// take mem_rdata directly when their rdata_valid is high.
module imem_port_arbiter #(
  // Consecutive external grants allowed while IF is waiting (1..15).
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,

  // fetch stage
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_rdata_valid,

  // program loader (write)
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,

  // debug (read)
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic [31:0] dbg_addr,
  output logic        dbg_rdata_valid,

  // shared memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  // Encoding of the round-robin pointer: which external was served last.
  localparam logic EXT_LD  = 1'b0;
  localparam logic EXT_DBG = 1'b1;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  // Registered state
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       last_ext_q,  last_ext_d;
  owner_e     rd_owner_q,  rd_owner_d;

  // Current-cycle grant
  owner_e     grant;
  logic       if_starved;
  logic       ext_tie;

  // mem_rdata passes straight to the consumers; nothing in this block
  // looks at it, which keeps it off every control path.
  logic unused_mem_rdata;
  assign unused_mem_rdata = ^mem_rdata;

  // IF has waited through a full external burst and must go next.
  assign if_starved = if_req && (burst_cnt_q == MAX_B);
  assign ext_tie    = ld_valid && dbg_valid;

  // Grant decision. Reset forces no owner so every grant-derived output
  // drops as soon as reset goes low, not at the next edge.
  always_comb begin
    grant = OWN_NONE;
    if (!reset) begin
      grant = OWN_NONE;
    end else if (if_starved) begin
      grant = OWN_IF;
    end else if (ext_tie) begin
      grant = (last_ext_q == EXT_DBG) ? OWN_LD : OWN_DBG;
    end else if (ld_valid) begin
      grant = OWN_LD;
    end else if (dbg_valid) begin
      grant = OWN_DBG;
    end else if (if_req) begin
      grant = OWN_IF;
    end
  end

  // Next-state: burst counter, round-robin pointer, read owner.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    last_ext_d  = last_ext_q;
    rd_owner_d  = OWN_NONE;

    // Burst only accumulates while IF is actually waiting; an IF grant or
    // an idle IF cycle restarts it.
    if (!if_req || grant == OWN_IF) begin
      burst_cnt_d = 4'd0;
    end else if ((grant == OWN_LD || grant == OWN_DBG) && burst_cnt_q != MAX_B) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end

    // Pointer moves only on a completed external transfer.
    if (grant == OWN_LD) begin
      last_ext_d = EXT_LD;
    end else if (grant == OWN_DBG) begin
      last_ext_d = EXT_DBG;
    end

    // Loader writes return nothing, so only reads claim the next data cycle.
    if (grant == OWN_IF) begin
      rd_owner_d = OWN_IF;
    end else if (grant == OWN_DBG) begin
      rd_owner_d = OWN_DBG;
    end
  end

  // State register; reset leaves LD as winner of the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= 4'd0;
      last_ext_q  <= EXT_DBG;
      rd_owner_q  <= OWN_NONE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_ext_q  <= last_ext_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // Handshake outputs and memory port muxing from the grant.
  always_comb begin
    if_grant  = 1'b0;
    ld_ready  = 1'b0;
    dbg_ready = 1'b0;
    mem_addr  = if_addr;
    mem_wdata = 32'h0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    unique case (grant)
      OWN_IF: begin
        if_grant = 1'b1;
        mem_addr = if_addr;
        mem_re   = 1'b1;
      end
      OWN_LD: begin
        ld_ready  = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        mem_we    = 1'b1;
      end
      OWN_DBG: begin
        dbg_ready = 1'b1;
        mem_addr  = dbg_addr;
        mem_re    = 1'b1;
      end
      default: ;
    endcase
  end

  // Data-cycle indications for the read issued last cycle.
  always_comb begin
    if_rdata_valid  = (rd_owner_q == OWN_IF);
    dbg_rdata_valid = (rd_owner_q == OWN_DBG);
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small behavioral memory.
module tb_imem_port_arbiter;

  localparam int unsigned MAXB = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_rdata_valid;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [31:0] dbg_addr;
  logic        dbg_rdata_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  logic [31:0] tb_mem [0:255];

  imem_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .if_rdata_valid(if_rdata_valid),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
    .dbg_rdata_valid(dbg_rdata_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory, 1-cycle read latency, word addressed by addr[9:2].
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= tb_mem[mem_addr[9:2]];
    if (mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
  end

  function automatic logic [31:0] pre(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  task automatic clear_inputs;
    if_req = 0; if_addr = 0; ld_valid = 0; ld_addr = 0; ld_wdata = 0;
    dbg_valid = 0; dbg_addr = 0;
  endtask

  // Leaves time at posedge+1 with reset just released.
  task automatic apply_reset;
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    if_req = 1; ld_valid = 1; dbg_valid = 1;
    if_addr = 32'h10; ld_addr = 32'h14; dbg_addr = 32'h18; ld_wdata = 32'h1;
    #3;
    checks++; if (if_grant !== 1'b0) begin failures++; $display("FAIL rst_if_grant got=%b exp=0", if_grant); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (dbg_ready !== 1'b0) begin failures++; $display("FAIL rst_dbg_ready got=%b exp=0", dbg_ready); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL rst_mem_en got=%b exp=00", {mem_re, mem_we}); end
    repeat (2) @(posedge clk);
    #2;
    checks++; if ({if_rdata_valid, dbg_rdata_valid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {if_rdata_valid, dbg_rdata_valid}); end
    checks++; if ({mem_re, mem_we, if_grant} !== 3'b000) begin failures++; $display("FAIL rst_hold got=%b exp=000", {mem_re, mem_we, if_grant}); end
    // Release with a loader write pending: first edge must arbitrate.
    clear_inputs();
    ld_valid = 1; ld_addr = 32'h300; ld_wdata = 32'h77;
    @(posedge clk);
    #1 reset = 1;
    #2;
    checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL rel_ld got=%b%b exp=11", ld_ready, mem_we); end
    tick();
    ld_valid = 0; dbg_valid = 1; dbg_addr = 32'h300;
    tick();
    dbg_valid = 0;
    #2;
    checks++; if (dbg_rdata_valid !== 1'b1 || mem_rdata !== 32'h77) begin failures++; $display("FAIL rel_rd got=%b/%h exp=1/00000077", dbg_rdata_valid, mem_rdata); end
    tick();
  endtask

  task automatic test_if_only;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = 32'(i * 4);
      #2;
      checks++; if (if_grant !== 1'b1) begin failures++; $display("FAIL if_grant[%0d] got=%b exp=1", i, if_grant); end
      checks++; if (mem_addr !== 32'(i * 4) || mem_re !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL if_port[%0d] got=%h/%b%b exp=%h/10", i, mem_addr, mem_re, mem_we, 32'(i * 4)); end
      if (i == 0) begin
        checks++; if (if_rdata_valid !== 1'b0) begin failures++; $display("FAIL if_rv0 got=%b exp=0", if_rdata_valid); end
      end else begin
        checks++; if (if_rdata_valid !== 1'b1 || mem_rdata !== pre(i - 1)) begin failures++; $display("FAIL if_rv[%0d] got=%b/%h exp=1/%h", i, if_rdata_valid, mem_rdata, pre(i - 1)); end
      end
      tick();
    end
    if_req = 0;
    #2;
    checks++; if (if_grant !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL if_idle got=%b%b exp=00", if_grant, mem_re); end
    checks++; if (if_rdata_valid !== 1'b1 || mem_rdata !== pre(2)) begin failures++; $display("FAIL if_rv_last got=%b/%h exp=1/%h", if_rdata_valid, mem_rdata, pre(2)); end
    tick();
    #2;
    checks++; if (if_rdata_valid !== 1'b0) begin failures++; $display("FAIL if_rv_drop got=%b exp=0", if_rdata_valid); end
    tick();
  endtask

  task automatic test_burst;
    int if_cnt;
    if_cnt = 0;
    apply_reset();
    ld_valid = 1; if_req = 1; if_addr = 32'h20;
    for (int c = 0; c < 10; c++) begin
      logic exp_if;
      exp_if = ((c % 5) == 4);
      ld_addr = 32'h100 + 32'(c * 4);
      ld_wdata = 32'h1000 + 32'(c);
      #2;
      checks++; if (if_grant !== exp_if || ld_ready !== !exp_if || mem_we !== !exp_if) begin
        failures++; $display("FAIL burst[%0d] got=if%b ld%b we%b exp=if%b", c, if_grant, ld_ready, mem_we, exp_if);
      end
      if (if_grant) if_cnt++;
      tick();
    end
    checks++; if (if_cnt !== 2) begin failures++; $display("FAIL burst_if_duty got=%0d exp=2", if_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin;
    apply_reset();
    ld_valid = 1; dbg_valid = 1;
    ld_addr = 32'h200; ld_wdata = 32'h55; dbg_addr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      logic exp_ld;
      exp_ld = ((c % 2) == 0);
      #2;
      checks++; if (ld_ready !== exp_ld || dbg_ready !== !exp_ld || mem_addr !== (exp_ld ? 32'h200 : 32'h80)) begin
        failures++; $display("FAIL rr[%0d] got=ld%b dbg%b addr=%h exp_ld=%b", c, ld_ready, dbg_ready, mem_addr, exp_ld);
      end
      if (c > 0) begin
        checks++; if (dbg_rdata_valid !== exp_ld || (exp_ld && mem_rdata !== pre(32))) begin
          failures++; $display("FAIL rr_rv[%0d] got=%b/%h exp=%b/%h", c, dbg_rdata_valid, mem_rdata, exp_ld, pre(32));
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    ld_valid = 1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF;
    #2;
    checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL b2b_wr got=%b%b%b/%h exp=110/deadbeef", ld_ready, mem_we, mem_re, mem_wdata);
    end
    tick();
    ld_valid = 0; dbg_valid = 1; dbg_addr = 32'h40;
    #2;
    checks++; if (dbg_ready !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 32'h40) begin
      failures++; $display("FAIL b2b_rd got=%b%b/%h exp=11/00000040", dbg_ready, mem_re, mem_addr);
    end
    tick();
    dbg_valid = 0;
    #2;
    checks++; if (dbg_rdata_valid !== 1'b1 || mem_rdata !== 32'hDEADBEEF || if_rdata_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_data got=%b/%h if%b exp=1/deadbeef if0", dbg_rdata_valid, mem_rdata, if_rdata_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_read;
    clear_inputs();
    tick();
    dbg_valid = 1; dbg_addr = 32'h44;
    #2;
    checks++; if (dbg_ready !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b exp=1", dbg_ready); end
    #1 reset = 0;
    ld_valid = 1; if_req = 1;
    #1;
    checks++; if ({if_grant, ld_ready, dbg_ready, mem_re, mem_we} !== 5'b0) begin
      failures++; $display("FAIL mid_outs got=%b exp=00000", {if_grant, ld_ready, dbg_ready, mem_re, mem_we});
    end
    tick();
    #2;
    checks++; if ({if_rdata_valid, dbg_rdata_valid} !== 2'b00) begin failures++; $display("FAIL mid_drop got=%b exp=00", {if_rdata_valid, dbg_rdata_valid}); end
    clear_inputs();
    reset = 1;
    tick();
    #2;
    checks++; if (dbg_rdata_valid !== 1'b0) begin failures++; $display("FAIL mid_noreissue got=%b exp=0", dbg_rdata_valid); end
    tick();
  endtask

  task automatic test_random;
    int wait_cnt;
    logic prev_if, prev_dbg;
    wait_cnt = 0; prev_if = 0; prev_dbg = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      ld_valid  = ($urandom_range(0, 1) == 1);
      dbg_valid = ($urandom_range(0, 2) == 0);
      if_addr   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      ld_addr   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      dbg_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      ld_wdata  = $urandom;
      #2;
      checks++; if (mem_re && mem_we) begin failures++; $display("FAIL rnd_re_we[%0d] got=11 exp=not both", c); end
      checks++; if (!$onehot0({if_grant, ld_ready, dbg_ready})) begin failures++; $display("FAIL rnd_onehot[%0d] got=%b", c, {if_grant, ld_ready, dbg_ready}); end
      checks++; if ((if_grant && !if_req) || (ld_ready && !ld_valid) || (dbg_ready && !dbg_valid)) begin
        failures++; $display("FAIL rnd_ready_wo_valid[%0d] got=%b%b%b", c, if_grant, ld_ready, dbg_ready);
      end
      checks++; if (if_rdata_valid !== prev_if || dbg_rdata_valid !== prev_dbg) begin
        failures++; $display("FAIL rnd_rvalid[%0d] got=%b%b exp=%b%b", c, if_rdata_valid, dbg_rdata_valid, prev_if, prev_dbg);
      end
      checks++; if (dut.burst_cnt_q > 4'(MAXB)) begin failures++; $display("FAIL rnd_burst[%0d] got=%0d exp<=%0d", c, dut.burst_cnt_q, MAXB); end
      if (if_req && !if_grant) wait_cnt++;
      else wait_cnt = 0;
      checks++; if (wait_cnt > int'(MAXB)) begin failures++; $display("FAIL rnd_starve[%0d] got=%0d exp<=%0d", c, wait_cnt, MAXB); end
      prev_if = if_grant; prev_dbg = dbg_ready;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = pre(i);
    clear_inputs();
    reset = 0;
    test_reset();
    test_if_only();
    test_burst();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive external grants while IF is requesting; range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-004 if_req  in  1  fetch stage requests an instruction read this cycle.
REQ-005 if_addr  in  32  fetch address (pc).
REQ-006 if_grant  out  1  fetch read issued this cycle; 0 means fetch must hold pc (stall).
REQ-007 if_rdata_valid  out  1  mem_rdata holds the fetch result granted last cycle.
REQ-008 ld_valid / ld_ready  in / out  1 / 1  program-loader write handshake.
REQ-009 ld_addr, ld_wdata  in  32, 32  loader write address and data.
REQ-010 dbg_valid / dbg_ready  in / out  1 / 1  debug read handshake.
REQ-011 dbg_addr  in  32  debug read address.
REQ-012 dbg_rdata_valid  out  1  mem_rdata holds the debug result granted last cycle.
REQ-013 mem_addr, mem_wdata  out  32, 32  shared single-port instruction memory address and write data.
REQ-014 mem_re, mem_we  out  1, 1  memory read and write enables; never both high.
REQ-015 mem_rdata  in  32  memory read data; 1-cycle latency after mem_re.

Function
REQ-016 Exactly one owner per cycle, or none: IF, LD or DBG; grant decision combinational from current requests and registered state.
REQ-017 A transfer completes in the cycle the handshake is met: LD on ld_valid&&ld_ready, DBG on dbg_valid&&dbg_ready, IF on if_req&&if_grant.
REQ-018 External requesters (LD, DBG) take priority over IF unless burst_cnt==MAX_BURST and if_req=1; then IF is granted and externals see ready=0.
REQ-019 LD vs DBG both valid: round-robin via 1-bit pointer last_ext; the requester not served last wins; last_ext updates only on a completed external transfer.
REQ-020 burst_cnt (4 bits): +1 on each external grant while if_req=1; cleared on any IF grant or any cycle with if_req=0; saturates at MAX_BURST.
REQ-021 LD grant: mem_addr=ld_addr, mem_wdata=ld_wdata, mem_we=1, mem_re=0.
REQ-022 DBG grant: mem_addr=dbg_addr, mem_re=1, mem_we=0.
REQ-023 IF grant: mem_addr=if_addr, mem_re=1, mem_we=0.
REQ-024 No grant: mem_re=0, mem_we=0, mem_addr=if_addr, mem_wdata=0.
REQ-025 Register rd_owner (NONE/IF/DBG) each cycle from the grant; next cycle, if_rdata_valid=(rd_owner==IF) and dbg_rdata_valid=(rd_owner==DBG); at most one high.
REQ-026 LD write followed next cycle by DBG or IF read of the same address returns the new data; no bypass in this block.
REQ-027 if_grant=0 whenever if_req=0; ld_ready and dbg_ready are combinational grant indications and may be high only while the matching valid is high.
REQ-028 No combinational path from mem_rdata to any output except the data itself, which consumers take directly from mem_rdata.

Reset
REQ-029 While reset=0: if_grant, ld_ready, dbg_ready, mem_re, mem_we, if_rdata_valid, dbg_rdata_valid = 0; burst_cnt=0; last_ext=DBG (LD wins the first tie); rd_owner=NONE.
REQ-030 Reset asserted mid-read: the pending rdata_valid is dropped and not reissued; requesters re-present after reset release.
REQ-031 First posedge after reset release arbitrates normally.

Verification
REQ-032 IF only, if_req=1, if_addr=0,4,8 -> if_grant=1 each cycle, mem_addr follows, if_rdata_valid=1 one cycle later for each.
REQ-033 ld_valid=1 held, if_req=1, MAX_BURST=4 -> 4 LD writes, 1 IF grant, repeating; if_grant duty 1/5.
REQ-034 ld_valid and dbg_valid held, if_req=0 -> grants alternate LD, DBG, LD, DBG starting with LD after reset.
REQ-035 LD writes 0xDEADBEEF to 0x40, next cycle DBG reads 0x40 -> dbg_rdata_valid=1 with mem_rdata=0xDEADBEEF, if_rdata_valid=0.
REQ-036 DBG granted, reset pulled low before the data cycle -> dbg_rdata_valid stays 0; all outputs 0 during reset.
REQ-037 Random traffic, assertions: mem_re&&mem_we never; at most one of if_grant/ld_ready/dbg_ready; at most one rdata_valid; burst_cnt<=MAX_BURST.
